// File: rtl/deccnt_pkg.sv
// Shared types and display constants for the 4-digit BCD event counter.
// Cathode codes are {dp,g,f,e,d,c,b,a}, active-low; anodes are active-low with bit 0 = ones digit.
package deccnt_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        DIG_ONES,
        DIG_TENS,
        DIG_HUNDREDS,
        DIG_THOUSANDS
    } dig_sel_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] AN_ONES      = 4'b1110;
    localparam logic [3:0] AN_TENS      = 4'b1101;
    localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [3:0] AN_THOUSANDS = 4'b0111;

    function automatic logic [7:0] bcd_to_seg(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] anode_of(input dig_sel_e s);
        case (s)
            DIG_ONES:     return AN_ONES;
            DIG_TENS:     return AN_TENS;
            DIG_HUNDREDS: return AN_HUNDREDS;
            default:      return AN_THOUSANDS;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability-run debouncer and
// one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned    CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  RUN_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] run_q, run_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // The level flips on the DEB_CYCLES-th consecutive differing sample; any agreeing sample restarts the run.
    always_comb begin
        run_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (run_q == RUN_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                run_d = run_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            run_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            run_q   <= run_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/deccnt_top.sv
// Board top: debounced BTNC drives a 4-digit BCD counter shown on a
// multiplexed common-anode 7-segment display, low two digits mirrored on LEDs.
module deccnt_top
    import deccnt_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 8,
    parameter int unsigned SCAN_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTNU,
    input  logic        BTNL,
    input  logic        BTNC,
    input  logic        BTNR,
    input  logic        BTND,
    output logic [11:0] SEG,
    output logic [7:0]  LED
);

    localparam int unsigned   TW         = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_CYCLES - 1);

    logic unused_reserved;
    logic unused_btn_level;
    logic inc;

    bcd_t [3:0]    cnt_q, cnt_d;
    logic          carry;
    logic [TW-1:0] timer_q, timer_d;
    dig_sel_e      sel_q, sel_d;
    logic [11:0]   seg_q, seg_d;
    logic [7:0]    led_q;

    assign unused_reserved = ^{BTNU, BTNL, BTNR, BTND};

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .btn_i  (BTNC),
        .level_o(unused_btn_level),
        .press_o(inc)
    );

    // Ripple the increment through the digits; a digit only advances while carry is still live.
    always_comb begin
        cnt_d = cnt_q;
        carry = inc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt_q[i] >= 4'd9) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        timer_d = timer_q + TW'(1);
        sel_d   = sel_q;
        if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            case (sel_q)
                DIG_ONES:     sel_d = DIG_TENS;
                DIG_TENS:     sel_d = DIG_HUNDREDS;
                DIG_HUNDREDS: sel_d = DIG_THOUSANDS;
                default:      sel_d = DIG_ONES;
            endcase
        end
    end

    // Anode and cathode fields come from one register so they always switch together.
    assign seg_d = {anode_of(sel_q), bcd_to_seg(cnt_q[sel_q])};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q   <= '0;
            timer_q <= '0;
            sel_q   <= DIG_ONES;
            seg_q   <= {AN_ONES, SEG_0};
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            led_q   <= {cnt_q[1], cnt_q[0]};
        end
    end

    assign SEG = seg_q;
    assign LED = led_q;

endmodule

// File: tb/tb_deccnt_top.sv
// Self-checking bench for deccnt_top: press-pattern table, LED scoreboard and
// hand-written multi-cycle sequences (latency, glitches, carries, wrap, reset mid-press).
module tb_deccnt_top;

    localparam int DEB = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BTNU, BTNL, BTNC, BTNR, BTND;
    logic [11:0] SEG;
    logic [7:0]  LED;

    int checks = 0;
    int errors = 0;

    deccnt_top #(
        .DEB_CYCLES (DEB),
        .SCAN_CYCLES(16)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .BTNU (BTNU),
        .BTNL (BTNL),
        .BTNC (BTNC),
        .BTNR (BTNR),
        .BTND (BTND),
        .SEG  (SEG),
        .LED  (LED)
    );

    always #5 CLK = ~CLK;

    logic [7:0] cath_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        int         hi;
        int         lo;
        logic [7:0] exp_led;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    logic [7:0] led_prev = 8'h00;
    bit         mon_en = 1'b0;
    bit         rsv_toggle = 1'b0;
    int         x_seen = 0;
    int         model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] led_of(input int n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int digit_of(input int n, input int idx);
        int p = 1;
        for (int j = 0; j < idx; j++) p = p * 10;
        return (n / p) % 10;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rsv_toggle) {BTNU, BTNL, BTNR, BTND} = 4'($urandom);
    endtask

    task automatic press(input int hi, input int lo);
        if (hi >= DEB) begin
            model_cnt = (model_cnt + 1) % 10000;
            exp_q.push_back(led_of(model_cnt));
        end
        BTNC = 1'b1;
        repeat (hi) tick();
        BTNC = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic seg_view(input string name);
        int bad_an = 0;
        int mism   = 0;
        int idx;
        for (int k = 0; k < 64; k++) begin
            tick();
            case (SEG[11:8])
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) bad_an++;
            else if (SEG[7:0] !== cath_tbl[digit_of(model_cnt, idx)]) mism++;
        end
        check({name, "_anode"}, bad_an, 0);
        check({name, "_cathode"}, mism, 0);
    endtask

    // LED scoreboard: every change must match the oldest predicted value.
    always @(negedge CLK) begin
        if (mon_en) begin
            if ($isunknown({SEG, LED})) x_seen++;
            if (LED !== led_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL led_unexpected: got %0h expected no change from %0h", LED, led_prev);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("led_scoreboard", LED, exp_v);
                end
                led_prev = LED;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [3:0] an_exp [5];

        vecs[0] = '{20, 20,  8'h02};
        vecs[1] = '{20, 500, 8'h03};
        vecs[2] = '{5,  20,  8'h03};
        vecs[3] = '{7,  20,  8'h03};
        vecs[4] = '{8,  20,  8'h04};
        vecs[5] = '{9,  20,  8'h05};
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        RESET = 1'b0;
        BTNC  = 1'b0;
        {BTNU, BTNL, BTNR, BTND} = 4'bzzzz;

        // Reset held 100 ns with clock running
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3 || k == 9) begin
                check("reset_seg", SEG, 12'hEC0);
                check("reset_led", LED, 8'h00);
            end
        end
        RESET = 1'b1;

        // Scan order after release: anode advances every 16 cycles, all digits C0
        for (int k = 1; k <= 72; k++) begin
            tick();
            if (k % 16 == 8) check("scan_after_reset", SEG, {an_exp[k / 16], 8'hC0});
        end

        led_prev = LED;
        mon_en   = 1'b1;

        // Single press latency: LED follows BTNC rise by DEB+4 cycles
        model_cnt = 1;
        exp_q.push_back(8'h01);
        BTNC = 1'b1;
        lat  = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 20) BTNC = 1'b0;
            if (lat == 0 && LED == 8'h01) lat = k;
        end
        check("press_latency", lat, 12);
        check("single_led", LED, 8'h01);
        seg_view("single_seg");

        // Table of press patterns, including the DEB_CYCLES boundary
        foreach (vecs[i]) begin
            press(vecs[i].hi, vecs[i].lo);
            check("vec_led", LED, vecs[i].exp_led);
        end
        seg_view("vec_seg");

        // Glitch rejection: 5 high then toggle every 3 cycles
        BTNC = 1'b1;
        repeat (5) tick();
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) BTNC = ~BTNC;
            tick();
        end
        BTNC = 1'b0;
        repeat (20) tick();
        check("glitch_led", LED, 8'h05);

        // Reserved buttons toggling during presses
        rsv_toggle = 1'b1;
        repeat (3) press(12, 14);
        rsv_toggle = 1'b0;
        {BTNU, BTNL, BTNR, BTND} = 4'bzzzz;
        check("reserved_led", LED, 8'h08);

        // Carries: 10, then 99 -> 100
        while (model_cnt < 10) press(10, 12);
        check("carry_10", LED, 8'h10);
        while (model_cnt < 99) press(10, 12);
        check("carry_99", LED, 8'h99);
        press(10, 12);
        check("carry_100_led", LED, 8'h00);
        lat = 0;
        for (int k = 0; k < 64 && lat == 0; k++) begin
            tick();
            if (SEG[11:8] == 4'b1011) lat = 1;
        end
        check("carry_100_hundreds", {lat[7:0], SEG[7:0]}, {8'd1, 8'hF9});
        seg_view("carry_100_seg");

        // Wrap: preload 9999 then one press
        exp_q.push_back(8'h99);
        force dut.cnt_q = 16'h9999;
        tick();
        tick();
        release dut.cnt_q;
        model_cnt = 9999;
        repeat (3) tick();
        check("preload_led", LED, 8'h99);
        seg_view("preload_seg");
        press(10, 12);
        check("wrap_led", LED, 8'h00);
        seg_view("wrap_seg");

        // Reset while the button is held: clears, then the held level counts once
        model_cnt = 1;
        exp_q.push_back(8'h01);
        BTNC = 1'b1;
        repeat (20) tick();
        exp_q.push_back(8'h00);
        RESET = 1'b0;
        repeat (5) tick();
        check("midreset_seg", SEG, 12'hEC0);
        check("midreset_led", LED, 8'h00);
        exp_q.push_back(8'h01);
        RESET = 1'b1;
        repeat (30) tick();
        BTNC = 1'b0;
        repeat (20) tick();
        check("midreset_after", LED, 8'h01);

        check("scoreboard_drained", exp_q.size(), 0);
        check("no_x_outputs", x_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deccnt_top.md
Name: deccnt_top

Overview:
- Board-level 4-digit decimal (BCD) event counter for a push-button/7-segment board.
- Each debounced press of the centre button BTNC increments the count 0000..9999.
- The count is shown on a time-multiplexed 4-digit common-anode 7-segment display.
- The low two digits are mirrored on LEDs.

Parameters:
- DEB_CYCLES, 8: consecutive stable clock cycles required before a synchronised button level is accepted.
- SCAN_CYCLES, 16: clock cycles each display digit stays selected before the scan advances.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- BTNU  input  1  reserved, ignored (may float).
- BTNL  input  1  reserved, ignored (may float).
- BTNC  input  1  count button, active-high, asynchronous to CLK.
- BTNR  input  1  reserved, ignored (may float).
- BTND  input  1  reserved, ignored (may float).
- SEG  output  12  [11:8] digit anodes, active-low, bit 8 = ones digit; [7:0] cathodes {dp,g,f,e,d,c,b,a}, active-low.
- LED  output  8  [3:0] ones digit BCD, [7:4] tens digit BCD, active-high.

Behaviour:
- Reset (RESET=0), applied immediately and asynchronously:
  - count = 0000, scan index = 0, scan timer = 0, debouncer state = released.
  - SEG = 12'hEC0; LED = 8'h00.
- Reserved buttons: no effect on any state. X or Z on them must not propagate.
- Button path:
  - BTNC passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the run.
  - A rising edge of the debounced level produces a one-cycle inc pulse.
  - Latency from BTNC rising to count update is exactly DEB_CYCLES+3 cycles.
  - Exactly one increment per press, however long it is held. Release produces nothing.
  - A press shorter than DEB_CYCLES cycles is ignored.
- Counter:
  - Four cascaded BCD digits, each 0..9.
  - A digit wraps 9→0 with a carry into the next digit.
  - 9999 + 1 → 0000, with no flag.
  - Digits never take values A..F.
- Display scan:
  - The timer counts 0..SCAN_CYCLES-1. On terminal count the index advances 0→1→2→3→0.
  - Anode pattern by index: 0=1110, 1=1101, 2=1011, 3=0111. Exactly one anode is low outside reset.
  - Cathodes show the selected digit. Leading zeros are displayed. dp is always 1 (off).
  - Cathode codes [7:0]: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - SEG is registered. Anode and cathode fields change on the same clock edge, so there is no mismatched glitch frame.
  - SEG reflects a new count no later than the next time that digit is selected.
- LED: registered copy of {tens, ones}, updated 1 cycle after the count changes.
- Reset mid-press: the count clears. While the button is still held after reset release, the debouncer accepts that level as a new press (one increment).

Decomposition:
- Package deccnt_pkg:
  - 7-segment cathode constants for digits 0..9 and blank.
  - Anode pattern constants.
  - Digit-type typedef (4-bit BCD).
- Sub-module btn_debounce (parameter DEB_CYCLES):
  - Contains the synchroniser, stability counter and rising-edge pulse.
  - Ports: clock, reset, raw button, debounced level, press pulse.
- Counter, scan mux and decoder stay in deccnt_top.

Test Plan:
- Reset:
  - Stimulus: hold RESET=0 for 100 ns with the clock running.
  - Response: SEG=12'hEC0, LED=00 throughout. After release, the anodes cycle 1110→1101→1011→0111 every 16 cycles, with cathodes C0 on each digit.
- Single press:
  - Stimulus: BTNC high for 20 cycles.
  - Response: LED becomes 01 exactly 12 cycles after the rising edge (count update at DEB_CYCLES+3 = 11, LED 1 cycle later). SEG shows F9 on the ones anode and C0 on the others.
- Two presses:
  - Stimulus: 20 cycles high, 20 low, 20 high, then 500 cycles idle.
  - Response: LED=02, ones digit cathode A4, no further changes.
- Glitch rejection:
  - Stimulus: BTNC high for 5 cycles, then toggled every 3 cycles for 30 cycles.
  - Response: count stays 0000.
- Carry and wrap:
  - Stimulus: 10 presses, then 99 more, then continue to 10000 total presses (or preload via force).
  - Response: LED=10 after 10 presses; 0099+1 → LED=00 with digit 2 = F9 (count 0100); 9999+1 → 0000.
- Reserved inputs:
  - Stimulus: BTNU/BTNL/BTNR/BTND left floating or toggled during a count.
  - Response: count and outputs are identical to a run without them, with no X on SEG or LED.
